spin_ctrl: RTL and testbench



---
 rtl/spin_pkg.sv | 16 +
 rtl/lfsr8.sv | 28 ++
 rtl/spin_ctrl.sv | 125 ++++++++++++
 tb/tb_spin_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/spin_pkg.sv
// Shared types and constants for the LED wheel spinner: FSM states, default
// wheel size and the 8-bit LFSR seed/feedback taps.
package spin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        SLOW = 2'd2
    } state_e;

    localparam int         NUM_POS_DEF = 6;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    // Feedback from bits 7,5,4,3 realises x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] LFSR_TAPS   = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; shifts every cycle and, being maximal
// length from a non-zero seed, never reaches the all-zero lock-up state.
module lfsr8
    import spin_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [7:0] value_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/spin_ctrl.sv
// LED wheel spinner: fast phase of a pseudo-random step count, then a slow
// phase with a growing step interval, then stop with a one-cycle done pulse.
module spin_ctrl
    import spin_pkg::*;
#(
    parameter int unsigned      NUM_POS    = NUM_POS_DEF,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [CNT_W-1:0] STEP_INIT  = 16'd2500,
    parameter logic [CNT_W-1:0] STEP_INC   = 16'd1500,
    parameter logic [CNT_W-1:0] STEP_MAX   = 16'd40000,
    parameter logic [7:0]       FAST_STEPS = 8'd18,
    parameter bit               RAND_EN    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic [2:0] pos_o,
    output logic       running_o,
    output logic       done_o
);

    if (STEP_INIT < 1 || FAST_STEPS < 1) begin : g_param_check
        $error("spin_ctrl: STEP_INIT and FAST_STEPS must both be at least 1");
    end

    localparam logic [2:0]       POS_LAST = 3'(NUM_POS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [7:0]       fast_left_q, fast_left_d;
    logic [2:0]       pos_q, pos_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic [7:0]       lfsr;
    logic [7:0]       rand_add;
    logic             step;
    logic [CNT_W:0]   interval_sum;
    logic             over_max;

    lfsr8 u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .value_o (lfsr)
    );

    assign rand_add     = RAND_EN ? (lfsr & 8'h0F) : 8'd0;
    assign step         = (tick_q == interval_q - CNT_ONE);
    // Widened by one bit so a large increment cannot wrap below the ceiling.
    assign interval_sum = {1'b0, interval_q} + {1'b0, STEP_INC};
    assign over_max     = interval_sum > {1'b0, STEP_MAX};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            interval_q  <= STEP_INIT;
            fast_left_q <= '0;
            pos_q       <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            interval_q  <= interval_d;
            fast_left_q <= fast_left_d;
            pos_q       <= pos_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SPIN;
            SPIN:    if (step && fast_left_q == 8'd1) state_d = SLOW;
            SLOW:    if (step && over_max) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_d      = tick_q;
        interval_d  = interval_q;
        fast_left_d = fast_left_q;
        pos_d       = pos_q;
        running_d   = running_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                running_d = 1'b0;
                if (start_i) begin
                    running_d   = 1'b1;
                    tick_d      = '0;
                    interval_d  = STEP_INIT;
                    fast_left_d = FAST_STEPS + rand_add;
                end
            end
            SPIN, SLOW: begin
                tick_d = tick_q + CNT_ONE;
                if (step) begin
                    tick_d = '0;
                    pos_d  = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
                    if (state_q == SPIN) begin
                        fast_left_d = fast_left_q - 8'd1;
                    end else if (over_max) begin
                        running_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        interval_d = interval_sum[CNT_W-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    assign pos_o     = pos_q;
    assign running_o = running_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_spin_ctrl.sv
// Directed bench for spin_ctrl with a short timing profile (interval 2, +2,
// ceiling 8, 4 fast steps), plus a second instance with the random extension.
module tb_spin_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic [2:0] pos_a, pos_b;
    logic       run_a, run_b;
    logic       done_a, done_b;
    logic [7:0] ref_lfsr;

    int vecs = 0;
    int errs = 0;

    spin_ctrl #(
        .NUM_POS(6), .CNT_W(16), .STEP_INIT(16'd2), .STEP_INC(16'd2),
        .STEP_MAX(16'd8), .FAST_STEPS(8'd4), .RAND_EN(1'b0)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
        .pos_o(pos_a), .running_o(run_a), .done_o(done_a)
    );

    spin_ctrl #(
        .NUM_POS(6), .CNT_W(16), .STEP_INIT(16'd2), .STEP_INC(16'd2),
        .STEP_MAX(16'd8), .FAST_STEPS(8'd4), .RAND_EN(1'b1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
        .pos_o(pos_b), .running_o(run_b), .done_o(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference x^8+x^6+x^5+x^4+1 generator, seeded like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_lfsr <= 8'hA5;
        else        ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps completed by cycle c of the short profile, counted from SPIN entry.
    function automatic int steps_at(input int c);
        if (c >= 28) return 8;
        if (c >= 20) return 7;
        if (c >= 14) return 6;
        if (c >= 10) return 5;
        if (c >= 8)  return 4;
        if (c >= 6)  return 3;
        if (c >= 4)  return 2;
        if (c >= 2)  return 1;
        return 0;
    endfunction

    task automatic run_seq(input bit disturb, input int last_c, input int p0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_running", int'(run_a), 1);
        chk("start_pos", int'(pos_a), p0);
        for (int c = 1; c <= last_c; c++) begin
            tick();
            start_a = 1'b0;
            chk($sformatf("pos_c%0d", c), int'(pos_a), (p0 + steps_at(c)) % 6);
            chk($sformatf("run_c%0d", c), int'(run_a), (c < 28) ? 1 : 0);
            chk($sformatf("done_c%0d", c), int'(done_a), (c == 28) ? 1 : 0);
            if (disturb && (c == 3 || c == 15)) start_a = 1'b1;
        end
    endtask

    initial begin
        int n_fast;
        int stop_c;
        bit seen;

        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        #22;
        chk("rst_pos", int'(pos_a), 0);
        chk("rst_run", int'(run_a), 0);
        chk("rst_done", int'(done_a), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_run", int'(run_a), 0);

        run_seq(1'b0, 29, 0);
        run_seq(1'b1, 29, 2);

        run_seq(1'b0, 12, 4);
        chk("pre_rst_pos", int'(pos_a), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pos", int'(pos_a), 0);
        chk("midrst_run", int'(run_a), 0);
        chk("midrst_done", int'(done_a), 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_done", int'(done_a), 0);
            chk("postrst_run", int'(run_a), 0);
        end
        run_seq(1'b0, 29, 0);

        n_fast  = 4 + int'(ref_lfsr[3:0]);
        start_b = 1'b1;
        tick();
        chk("rand_start_run", int'(run_b), 1);
        stop_c = 0;
        seen   = 1'b0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            tick();
            if (done_b) begin
                seen   = 1'b1;
                stop_c = c;
            end
        end
        chk("rand_stop_cycle", seen ? stop_c : -1, 2 * n_fast + 20);
        chk("rand_stop_pos", int'(pos_b), (n_fast + 4) % 6);
        chk("rand_stop_run", int'(run_b), 0);
        tick();
        chk("rearm_run", int'(run_b), 1);
        chk("rearm_done", int'(done_b), 0);
        chk("rearm_pos", int'(pos_b), (n_fast + 4) % 6);
        start_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
